// File: rtl/score_buffer_writer.sv
// score_buffer_writer: streams signed scores into memory at base+index, then strobes the downstream scanner
module score_buffer_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] size,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  busy,
    output logic                  done,
    output logic                  consumer_start
);
    typedef enum logic [1:0] {IDLE, FILL, COMMIT, FINISH} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] size_q, base_q;
    logic [ADDR_WIDTH-1:0] count_inc;
    assign count_inc = count + ADDR_WIDTH'(1);
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // next state and state-decoded outputs; COMMIT covers the cycle the last write is on the port
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        consumer_start = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = (size != '0) ? FILL : FINISH;
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && count_inc == size_q) state_nx = COMMIT;
            end
            COMMIT: state_nx = FINISH;
            FINISH: begin
                done = 1'b1;
                consumer_start = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // job latch, element counter and registered write port; address wraps modulo 2^ADDR_WIDTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            count <= '0;
            size_q <= '0;
            base_q <= '0;
        end else begin
            mem_we <= 1'b0;
            if (state == IDLE && start) begin
                count <= '0;
                size_q <= size;
                base_q <= base_addr;
            end
            if (state == FILL && in_valid) begin
                mem_we <= 1'b1;
                mem_addr <= base_q + count;
                mem_wdata <= in_data;
                count <= count_inc;
            end
        end
    end
endmodule

// File: tb/tb_score_buffer_writer.sv
// tb_score_buffer_writer: randomized and directed fills checked by a write/done scoreboard
module tb_score_buffer_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [15:0] size = '0;
    logic [15:0] base_addr = '0;
    logic in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic in_ready, mem_we, busy, done, consumer_start;
    logic [15:0] mem_addr, count;
    logic [31:0] mem_wdata;

    score_buffer_writer dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .busy(busy), .done(done), .consumer_start(consumer_start)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    logic [47:0] exp_q[$];
    logic [15:0] done_q[$];
    logic [31:0] src_q[$];
    bit vpat[$];
    bit done_seen = 1'b0;
    bit prev_we = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: every write and every done pulse must match what the model queued
    always @(negedge clk) begin
        logic [47:0] e;
        logic [15:0] s;
        if (!rst) begin
            if (mem_we) begin
                if (exp_q.size() == 0) chk("unexpected_write", 64'(mem_addr), 64'hDEAD);
                else begin
                    e = exp_q.pop_front();
                    chk("mem_addr", 64'(mem_addr), 64'(e[47:32]));
                    chk("mem_wdata", 64'(mem_wdata), 64'(e[31:0]));
                end
            end
            if (consumer_start !== done) chk("consumer_start", 64'(consumer_start), 64'(done));
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done", 64'(done), 64'(0));
                else begin
                    s = done_q.pop_front();
                    chk("done_count", 64'(count), 64'(s));
                    chk("done_after_last_write", 64'(prev_we), 64'(s != 0));
                    chk("done_pending_writes", 64'(exp_q.size()), 64'(0));
                    chk("done_with_we", 64'(mem_we), 64'(0));
                    done_seen = 1'b1;
                end
            end
            prev_we = mem_we;
        end else prev_we = 1'b0;
    end

    // driver plus reference model: the first sz valid beats after start land at ba, ba+1, ... in order
    task automatic fill(input logic [15:0] sz, input logic [15:0] ba, input int gap,
                        input int restart_at, input int rst_after);
        int k = 0;
        int n = 0;
        int m = 0;
        bit v;
        logic [31:0] d;
        @(negedge clk);
        start = 1'b1;
        size = sz;
        base_addr = ba;
        done_seen = 1'b0;
        done_q.push_back(sz);
        @(negedge clk);
        start = 1'b0;
        size = 16'($urandom);
        base_addr = 16'($urandom);
        while (k < int'(sz) && n < 400) begin
            v = (vpat.size() != 0) ? vpat.pop_front() : (int'($urandom_range(99)) >= gap);
            d = (src_q.size() != 0) ? src_q[0] : $urandom;
            if (v && src_q.size() != 0) void'(src_q.pop_front());
            in_valid = v;
            in_data = v ? d : $urandom;
            start = (n == restart_at);
            if (n == restart_at) size = 16'd2;
            chk("in_ready_fill", 64'(in_ready), 64'(1));
            if (v) begin
                exp_q.push_back({ba + k[15:0], d});
                k++;
            end
            n++;
            if (rst_after != 0 && v && k == rst_after) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                chk("rst_mem_we", 64'(mem_we), 64'(0));
                chk("rst_in_ready", 64'(in_ready), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_count", 64'(count), 64'(0));
                in_valid = 1'b0;
                exp_q.delete();
                done_q.delete();
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b1;
        in_data = $urandom;
        chk("in_ready_after_fill", 64'(in_ready), 64'(0));
        chk("busy_after_fill", 64'(busy), 64'(1));
        while (!done_seen && m < 20) begin
            @(posedge clk);
            m++;
        end
        if (!done_seen) chk("done_timeout", 64'(done_seen), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("held_count", 64'(count), 64'(sz));
        chk("writes_outstanding", 64'(exp_q.size()), 64'(0));
        vpat.delete();
        src_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        chk("reset_mem_we", 64'(mem_we), 64'(0));
        chk("reset_mem_addr", 64'(mem_addr), 64'(0));
        chk("reset_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("reset_count", 64'(count), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'({done, consumer_start}), 64'(0));
        rst = 1'b0;
        src_q = '{-32'sd5, 32'sd3, -32'sd2, 32'sd8, 32'sd0, -32'sd1, 32'sd12, -32'sd7, 32'sd4, 32'sd7};
        fill(16'd10, 16'h0000, 0, -1, 0);
        vpat = '{1, 0, 0, 1, 1, 0, 1};
        fill(16'd4, 16'h0000, 0, -1, 0);
        fill(16'd0, 16'h1234, 0, -1, 0);
        src_q = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        fill(16'd4, 16'hFFFE, 0, -1, 0);
        fill(16'd6, 16'h0100, 0, 2, 0);
        fill(16'd8, 16'h0020, 0, -1, 3);
        fill(16'd2, 16'h0040, 0, -1, 0);
        for (int t = 0; t < 10; t++)
            fill(16'($urandom_range(1, 12)),
                 ($urandom_range(1) != 0) ? 16'hFFF8 + 16'($urandom_range(7)) : 16'($urandom),
                 30, -1, 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
